salida_pop_reader: RTL and testbench
====================================

// Module: salida_pop_reader
// PURPOSE
//  Consumer end of the 4-in/4-out routing FIFO fabric: drains output FIFOs 4..7 via pop4..pop7.
//  Round-robin arbitration; one pop per cycle, full throughput when downstream is ready.
//  Merges words into one valid/ready stream tagged with channel; checks routing; counts words.
// PARAMETERS
//  DATA_W   10  word width; [DATA_W-1:DATA_W-2] = destination id, [DATA_W-3:0] = payload
//  BUF_D    2   internal output buffer depth (entries)
//  CNT_W    8   per-channel word counter width (wraps)
// PORTS
//  clk          in   1        single clock, all state on posedge
//  reset        in   1        asynchronous, active-high
//  init         in   1        sync pulse: clear counters/errors, arm reader (IDLE->ACTIVE)
//  enable       in   1        0 = stop issuing pops (ACTIVE->DRAIN)
//  empty4..7    in   1 each   FIFO empty flag of output FIFO 4..7
//  data4..7     in   DATA_W   FIFO read data; valid exactly 1 cycle after its pop
//  pop4..7      out  1 each   one-cycle pop strobe, at most one high per cycle
//  ready_out    in   1        downstream accepts data_out this cycle
//  valid_out    out  1        data_out/ch_out valid
//  data_out     out  DATA_W   word at buffer head
//  ch_out       out  2        source FIFO index (0=FIFO4 .. 3=FIFO7) of data_out
//  cnt0..3      out  CNT_W    words delivered (valid_out&ready_out) per channel
//  err_dest     out  4        sticky: bit i set if word from FIFO 4+i had dest id != i
//  busy         out  1        state != IDLE or buffer non-empty or pop in flight
// BEHAVIOUR
//  Reset: pop*=0, valid_out=0, data_out=0, ch_out=0, cnt*=0, err_dest=0, busy=0,
//   FSM=IDLE, rr pointer=0, buffer empty, in-flight=0.
//  FSM: IDLE --init--> ACTIVE; ACTIVE --!enable--> DRAIN; DRAIN --in-flight=0 & buf empty--> IDLE;
//   DRAIN --enable--> ACTIVE. init in any state: clears cnt*/err_dest same cycle, goes ACTIVE,
//   buffer contents and in-flight word are kept (no data loss).
//  Pop issue (ACTIVE only): proj = occ + inflight - (valid_out&ready_out); pop allowed iff proj < BUF_D.
//   Grant: first non-empty channel starting at rr pointer; rr <= granted+1 mod 4; no grant -> rr unchanged.
//   Never pop a channel whose empty is 1 in the same cycle.
//  Capture: cycle after popN, data(N) written to buffer with ch tag; inflight flag cleared.
//   Same-cycle write and read of buffer allowed; buffer is FIFO order = pop order.
//  Output: valid_out = buffer non-empty; data_out/ch_out = head, held stable while valid_out & !ready_out.
//  Latency: pop -> valid_out 2 cycles (pop, capture, visible next cycle) with empty buffer.
//  Counters: cnt[ch_out] += 1 on valid_out&ready_out, wraps 2^CNT_W-1 -> 0.
//  Routing check at capture: data[DATA_W-1:DATA_W-2] != ch -> err_dest[ch] <= 1 (sticky till init/reset).
//  Boundaries: buffer full & !ready_out -> no pop; all empty -> no pop, no rr change;
//   enable low with word in flight -> word still captured and delivered;
//   reset mid-transfer -> in-flight word discarded (FIFO already popped; accepted loss).
// STRUCTURE
//  Shared package/header: DATA_W, CH_W=2, FSM state encodings (IDLE/ACTIVE/DRAIN).
//  Sub-module: rr_arbiter4 (4 requests, pointer in, one-hot grant + index out), combinational.
//  Top: FSM, credit/occupancy logic, BUF_D-entry buffer (data+tag), counters, error flags.
// TESTING
//  1 reset then init, FIFO4..7 each hold 1 word (dest 0..3, payload ff/ee/dd/cc), ready_out=1
//    -> pops 4,5,6,7 on consecutive cycles; data_out 0x0ff,0x1ee,0x2dd,0x3cc, cnt*=1, err_dest=0.
//  2 only FIFO6 non-empty with 5 words, ready_out=1 -> pop6 high 5 consecutive cycles, cnt2=5.
//  3 ready_out=0, all FIFOs non-empty -> exactly 2 pops then none; data_out held; release
//    ready_out -> resumes, no word lost or duplicated.
//  4 word 0x1aa in FIFO4 -> err_dest=4'b0001, sticky; init pulse -> err_dest=0, cnt*=0.
//  5 enable dropped the cycle after a pop -> that word delivered, no further pops, FSM->IDLE, busy=0.
//  6 reset asserted with buffer full -> all outputs zero immediately (async), rr pointer=0.

Source files
------------

// File: rtl/salida_pop_reader_pkg.sv
// Shared constants and FSM encoding for the salida pop reader.
// Every file of this block imports this package.
package salida_pop_reader_pkg;

  localparam int DATA_W = 10;
  localparam int CH_W   = 2;
  localparam int N_CH   = 4;
  localparam int BUF_D  = 2;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/salida_pop_reader_rr_arbiter4.sv
// Four-way round-robin arbiter. Combinational only: it grants the first
// requesting channel at or after the pointer, and reports its index.
module salida_pop_reader_rr_arbiter4
  import salida_pop_reader_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] idx,
  output logic            any
);

  logic [CH_W-1:0] cand;

  // Scan channels starting at the pointer and keep the first requester found
  always_comb begin
    grant = '0;
    idx   = ptr;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = ptr + CH_W'(i);
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/salida_pop_reader.sv
// Consumer end of the routing FIFO fabric. Drains output FIFOs 4..7 with a
// round-robin pop, captures each word the cycle after its pop into a small
// buffer, and presents the words as one valid/ready stream tagged with the
// source channel. Also counts delivered words and flags misrouted words.
module salida_pop_reader
  import salida_pop_reader_pkg::*;
#(
  parameter int DATA_W = salida_pop_reader_pkg::DATA_W,
  parameter int BUF_D  = salida_pop_reader_pkg::BUF_D,
  parameter int CNT_W  = salida_pop_reader_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              enable,
  input  logic              empty4,
  input  logic              empty5,
  input  logic              empty6,
  input  logic              empty7,
  input  logic [DATA_W-1:0] data4,
  input  logic [DATA_W-1:0] data5,
  input  logic [DATA_W-1:0] data6,
  input  logic [DATA_W-1:0] data7,
  output logic              pop4,
  output logic              pop5,
  output logic              pop6,
  output logic              pop7,
  input  logic              ready_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CH_W-1:0]   ch_out,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  cnt2,
  output logic [CNT_W-1:0]  cnt3,
  output logic [N_CH-1:0]   err_dest,
  output logic              busy
);

  localparam int OCC_W  = $clog2(BUF_D + 1);
  localparam int PROJ_W = OCC_W + 1;
  localparam int PTR_W  = (BUF_D > 1) ? $clog2(BUF_D) : 1;

  state_t state, state_nxt;

  logic [N_CH-1:0]   req;
  logic [N_CH-1:0]   grant;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_any;
  logic [CH_W-1:0]   rr_ptr;

  logic              inflight;
  logic [CH_W-1:0]   inflight_ch;
  logic [DATA_W-1:0] cap_data;

  logic [DATA_W-1:0] buf_data [BUF_D];
  logic [CH_W-1:0]   buf_ch   [BUF_D];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  occ;

  logic              deq;
  logic [PROJ_W-1:0] proj;
  logic              pop_ok;
  logic [N_CH-1:0]   pop_vec;
  logic              pop_fire;

  logic [CNT_W-1:0]  cnt [N_CH];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_D - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign req = ~{empty7, empty6, empty5, empty4};

  salida_pop_reader_rr_arbiter4 u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // The buffer head drives the stream; outputs read as zero while it is empty
  assign valid_out = (occ != '0);
  assign deq       = valid_out & ready_out;
  assign data_out  = valid_out ? buf_data[rd_ptr] : '0;
  assign ch_out    = valid_out ? buf_ch[rd_ptr]   : '0;

  // Entries that will be held after this edge if no new pop is issued
  assign proj = (PROJ_W'(occ) + PROJ_W'(inflight)) - PROJ_W'(deq);

  assign pop_fire = |pop_vec;
  assign {pop7, pop6, pop5, pop4} = pop_vec;

  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
  assign cnt2 = cnt[2];
  assign cnt3 = cnt[3];

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state: init re-arms from anywhere; enable steers ACTIVE/DRAIN
  always_comb begin
    state_nxt = state;
    if (init) begin
      state_nxt = ST_ACTIVE;
    end else begin
      case (state)
        ST_IDLE:   state_nxt = ST_IDLE;
        ST_ACTIVE: if (!enable) state_nxt = ST_DRAIN;
        ST_DRAIN: begin
          if (enable)                       state_nxt = ST_ACTIVE;
          else if (!inflight && !valid_out) state_nxt = ST_IDLE;
        end
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: a pop only when armed, enabled and the buffer has a free slot
  always_comb begin
    pop_ok  = (state == ST_ACTIVE) && enable && (proj < PROJ_W'(BUF_D));
    pop_vec = '0;
    if (pop_ok && grant_any) pop_vec = grant;
    busy    = (state != ST_IDLE) || valid_out || inflight;
  end

  // Round-robin pointer and the one-deep record of the word being fetched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_ch <= '0;
    end else begin
      inflight <= pop_fire;
      if (pop_fire) begin
        inflight_ch <= grant_idx;
        rr_ptr      <= grant_idx + 1'b1;
      end
    end
  end

  // Select the read data of the FIFO popped in the previous cycle
  always_comb begin
    case (inflight_ch)
      2'd0:    cap_data = data4;
      2'd1:    cap_data = data5;
      2'd2:    cap_data = data6;
      default: cap_data = data7;
    endcase
  end

  // Circular output buffer in pop order; write and read may share a cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_D; i++) begin
        buf_data[i] <= '0;
        buf_ch[i]   <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (inflight) begin
        buf_data[wr_ptr] <= cap_data;
        buf_ch[wr_ptr]   <= inflight_ch;
        wr_ptr           <= ptr_next(wr_ptr);
      end
      if (deq) rd_ptr <= ptr_next(rd_ptr);
      case ({inflight, deq})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Delivered-word counters and sticky routing errors, both cleared by init
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
      err_dest <= '0;
    end else if (init) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
      err_dest <= '0;
    end else begin
      if (deq) cnt[ch_out] <= cnt[ch_out] + CNT_W'(1);
      if (inflight && (cap_data[DATA_W-1:DATA_W-2] != inflight_ch))
        err_dest[inflight_ch] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_salida_pop_reader.sv
// Self-checking bench for salida_pop_reader: behavioural FIFOs feed the DUT,
// expected words are queued as they are loaded and compared on delivery.
module tb_salida_pop_reader;
  import salida_pop_reader_pkg::*;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset, init, enable, ready_out;
  logic [3:0]        empty;
  logic [DATA_W-1:0] fdata [4];
  logic              pop4, pop5, pop6, pop7;
  logic              valid_out, busy;
  logic [DATA_W-1:0] data_out;
  logic [CH_W-1:0]   ch_out;
  logic [CNT_W-1:0]  cnt0, cnt1, cnt2, cnt3;
  logic [3:0]        err_dest;

  logic [DATA_W-1:0] fq [4][$];
  exp_t              exp_q[$];
  int                pop_log[$];
  int                pop_cyc[$];
  int                deliv_cyc[$];
  logic [3:0]        pend;
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;

  salida_pop_reader dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .enable    (enable),
    .empty4    (empty[0]),
    .empty5    (empty[1]),
    .empty6    (empty[2]),
    .empty7    (empty[3]),
    .data4     (fdata[0]),
    .data5     (fdata[1]),
    .data6     (fdata[2]),
    .data7     (fdata[3]),
    .pop4      (pop4),
    .pop5      (pop5),
    .pop6      (pop6),
    .pop7      (pop7),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ch_out    (ch_out),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3),
    .err_dest  (err_dest),
    .busy      (busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic [DATA_W-1:0] word, input bit expect_out);
    fq[ch].push_back(word);
    empty[ch] = 1'b0;
    if (expect_out) exp_q.push_back({CH_W'(ch), word});
  endtask

  task automatic monitor();
    logic [3:0] pops;
    exp_t e;
    pops = {pop7, pop6, pop5, pop4};
    if (reset) begin
      pend = '0;
      return;
    end
    pend = pops;
    if (pops != 4'b0000) begin
      checkOutput("pop_onehot", $countones(pops), 1);
      for (int i = 0; i < 4; i++) begin
        if (pops[i]) begin
          checkOutput("pop_on_empty", empty[i], 0);
          pop_log.push_back(i);
          pop_cyc.push_back(cyc);
        end
      end
    end
    if (valid_out && ready_out) begin
      deliv_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checkOutput("sb_extra_word", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_data", data_out, e.data);
        checkOutput("sb_ch", ch_out, e.ch);
      end
    end
  endtask

  // One clock: sample just after the falling edge, update FIFOs after rising edge
  task automatic tick();
    #1;
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 4; i++)
      if (pend[i] && fq[i].size() > 0) fdata[i] = fq[i].pop_front();
    for (int i = 0; i < 4; i++) empty[i] = (fq[i].size() == 0);
    @(negedge clk);
  endtask

  function automatic bit pending_work();
    return (exp_q.size() != 0) || (fq[0].size() != 0) || (fq[1].size() != 0) ||
           (fq[2].size() != 0) || (fq[3].size() != 0) || valid_out;
  endfunction

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (pending_work() && n < max_cycles) begin
      tick();
      n++;
    end
    checkOutput("drain_done", pending_work(), 0);
  endtask

  task automatic init_pulse();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) fq[i].delete();
    exp_q.delete();
    empty = 4'hF;
  endtask

  task automatic clear_logs();
    pop_log.delete();
    pop_cyc.delete();
    deliv_cyc.delete();
  endtask

  // Main stimulus sequence
  initial begin
    int n;
    reset = 1'b1; init = 1'b0; enable = 1'b0; ready_out = 1'b0;
    empty = 4'hF;
    for (int i = 0; i < 4; i++) fdata[i] = '0;
    #1;
    checkOutput("rst_valid", valid_out, 0);
    checkOutput("rst_data", data_out, 0);
    checkOutput("rst_ch", ch_out, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_pops", {pop7, pop6, pop5, pop4}, 0);
    checkOutput("rst_cnt", {cnt0, cnt1, cnt2, cnt3}, 0);
    checkOutput("rst_err", err_dest, 0);
    tick();
    tick();
    reset = 1'b0;

    $display("[TB] test 1: one word per FIFO");
    enable = 1'b1; ready_out = 1'b1;
    applyStimulus(0, 10'h0ff, 1'b1);
    applyStimulus(1, 10'h1ee, 1'b1);
    applyStimulus(2, 10'h2dd, 1'b1);
    applyStimulus(3, 10'h3cc, 1'b1);
    clear_logs();
    init_pulse();
    wait_drain(40);
    checkOutput("t1_pop_count", pop_log.size(), 4);
    for (int k = 0; k < pop_log.size(); k++) begin
      checkOutput("t1_pop_order", pop_log[k], k);
      checkOutput("t1_pop_consec", pop_cyc[k] - pop_cyc[0], k);
    end
    if (deliv_cyc.size() > 0 && pop_cyc.size() > 0)
      checkOutput("t1_latency", deliv_cyc[0] - pop_cyc[0], 2);
    checkOutput("t1_cnt", {cnt0, cnt1, cnt2, cnt3}, 32'h01010101);
    checkOutput("t1_err", err_dest, 0);

    $display("[TB] test 2: five words from FIFO6 only");
    init_pulse();
    clear_logs();
    for (int k = 0; k < 5; k++) applyStimulus(2, 10'h200 + 10'(k), 1'b1);
    wait_drain(40);
    checkOutput("t2_pop_count", pop_log.size(), 5);
    for (int k = 0; k < pop_log.size(); k++) begin
      checkOutput("t2_pop_ch", pop_log[k], 2);
      checkOutput("t2_pop_consec", pop_cyc[k] - pop_cyc[0], k);
    end
    checkOutput("t2_cnt2", cnt2, 5);
    checkOutput("t2_cnt0", cnt0, 0);

    $display("[TB] test 3: backpressure with all FIFOs loaded");
    do_reset();
    enable = 1'b1; ready_out = 1'b0;
    init_pulse();
    clear_logs();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++)
        applyStimulus(i, {2'(i), 8'(8'h10 * (r + 1) + i)}, 1'b1);
    repeat (10) tick();
    checkOutput("t3_pops_stalled", pop_log.size(), 2);
    checkOutput("t3_valid_held", valid_out, 1);
    checkOutput("t3_data_held", data_out, 10'h010);
    repeat (3) tick();
    checkOutput("t3_data_still", data_out, 10'h010);
    checkOutput("t3_ch_held", ch_out, 0);
    ready_out = 1'b1;
    wait_drain(60);
    checkOutput("t3_pop_total", pop_log.size(), 8);
    for (int k = 0; k < pop_log.size(); k++) checkOutput("t3_rr_order", pop_log[k], k % 4);
    checkOutput("t3_cnt", {cnt0, cnt1, cnt2, cnt3}, 32'h02020202);

    $display("[TB] test 4: misrouted word");
    applyStimulus(0, 10'h1aa, 1'b1);
    wait_drain(30);
    checkOutput("t4_err_set", err_dest, 4'b0001);
    applyStimulus(0, 10'h011, 1'b1);
    wait_drain(30);
    checkOutput("t4_err_sticky", err_dest, 4'b0001);
    checkOutput("t4_cnt0", cnt0, 4);
    init_pulse();
    checkOutput("t4_err_clear", err_dest, 0);
    checkOutput("t4_cnt_clear", {cnt0, cnt1, cnt2, cnt3}, 0);

    $display("[TB] test 5: enable dropped after a pop");
    clear_logs();
    applyStimulus(1, 10'h155, 1'b1);
    n = 0;
    while (pop_log.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("t5_pop_seen", pop_log.size(), 1);
    enable = 1'b0;
    fq[3].push_back(10'h3cc);
    empty[3] = 1'b0;
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_no_more_pops", pop_log.size(), 1);
    checkOutput("t5_delivered", exp_q.size(), 0);
    checkOutput("t5_cnt1", cnt1, 1);
    checkOutput("t5_fifo7_kept", fq[3].size(), 1);
    fq[3].delete();
    empty[3] = 1'b1;

    $display("[TB] test 6: async reset with full buffer");
    enable = 1'b1; ready_out = 1'b1;
    clear_logs();
    applyStimulus(1, 10'h1ab, 1'b1);
    init_pulse();
    wait_drain(30);
    checkOutput("t6_cnt1_pre", cnt1, 1);
    ready_out = 1'b0;
    applyStimulus(0, 10'h033, 1'b0);
    applyStimulus(1, 10'h144, 1'b0);
    repeat (8) tick();
    checkOutput("t6_pre_valid", valid_out, 1);
    checkOutput("t6_pre_pops", pop_log.size(), 3);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_valid", valid_out, 0);
    checkOutput("t6_data", data_out, 0);
    checkOutput("t6_ch", ch_out, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_pops", {pop7, pop6, pop5, pop4}, 0);
    checkOutput("t6_cnt", {cnt0, cnt1, cnt2, cnt3}, 0);
    checkOutput("t6_err", err_dest, 0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) fq[i].delete();
    exp_q.delete();
    empty = 4'hF;
    ready_out = 1'b1;
    clear_logs();
    for (int i = 0; i < 4; i++) applyStimulus(i, {2'(i), 8'h5a}, 1'b1);
    init_pulse();
    wait_drain(40);
    checkOutput("t6_pop_total", pop_log.size(), 4);
    if (pop_log.size() > 0) checkOutput("t6_rr_reset", pop_log[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
